// File: rtl/bench_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bench_pkg
// Brief   : Shared types, default taps and popcount helper for bench_act_gen.
// Revision: 1.0
// ============================================================================
package bench_pkg;

    typedef enum logic [1:0] {
        MODE_NOR  = 2'b00,
        MODE_XOR  = 2'b01,
        MODE_AND  = 2'b10,
        MODE_LFSR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_RUN   = 2'b10,
        ST_DRAIN = 2'b11
    } state_e;

    localparam logic [7:0] C_DEFAULT_TAPS = 8'hB8;

    // Callers zero-extend narrower vectors into the 64-bit argument.
    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bench_lfsr.sv
`default_nettype none
// ============================================================================
// Module  : bench_lfsr
// Brief   : Fibonacci LFSR, shift-left; a zero seed is replaced by 1.
// Revision: 1.0
// ============================================================================
module bench_lfsr
    import bench_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(C_DEFAULT_TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             adv,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= WIDTH'(1);
        end else if (load) begin
            q <= (seed == '0) ? WIDTH'(1) : seed;
        end else if (adv) begin
            q <= {q[WIDTH-2:0], ^(q & TAPS)};
        end
    end

endmodule
`default_nettype wire

// File: rtl/bench_act_gen.sv
`default_nettype none
// ============================================================================
// Module  : bench_act_gen
// Brief   : Switching-activity generator; optional toggle counter built only
//           when BENCH_TOGGLE_CNT_EN is defined.
// Revision: 1.0
// ============================================================================
module bench_act_gen
    import bench_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 3,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(C_DEFAULT_TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] x_in,
    output logic [WIDTH-1:0] y_out,
    output logic             y_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam int DCNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e             r_state;
    mode_e              r_mode;
    logic [WIDTH-1:0]   r_pipe [DEPTH];
    logic [DEPTH-1:0]   r_vld;
    logic [DCNT_W-1:0]  r_dcnt;
    logic [WIDTH-1:0]   w_lfsr;
    logic [WIDTH-1:0]   w_next_s;

    bench_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (r_state == ST_LOAD),
        .seed  (seed),
        .adv   (r_state == ST_RUN),
        .q     (w_lfsr)
    );

    // Stage 0 of the pipeline is the feedback state s.
    always_comb begin
        w_next_s = '0;
        unique case (r_mode)
            MODE_NOR:  w_next_s = ~(x_in | r_pipe[0]);
            MODE_XOR:  w_next_s = x_in ^ r_pipe[0];
            MODE_AND:  w_next_s = x_in & w_lfsr;
            MODE_LFSR: w_next_s = w_lfsr;
            default:   w_next_s = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_NOR;
            for (int k = 0; k < DEPTH; k++) begin
                r_pipe[k] <= '0;
            end
            r_vld   <= '0;
            r_dcnt  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == ST_RUN || r_state == ST_DRAIN) begin
                for (int k = 1; k < DEPTH; k++) begin
                    r_pipe[k] <= r_pipe[k-1];
                end
                r_vld <= (r_vld << 1) | DEPTH'(r_state == ST_RUN);
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        busy    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_mode <= mode_e'(mode);
                    for (int k = 0; k < DEPTH; k++) begin
                        r_pipe[k] <= '0;
                    end
                    r_vld   <= '0;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_pipe[0] <= w_next_s;
                    if (stop) begin
                        r_state <= ST_DRAIN;
                        r_dcnt  <= DCNT_W'(DEPTH - 1);
                        done    <= (DEPTH == 1);
                    end
                end
                ST_DRAIN: begin
                    if (r_dcnt == '0) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt - DCNT_W'(1);
                        done   <= (r_dcnt == DCNT_W'(1));
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign y_out   = r_pipe[DEPTH-1];
    assign y_valid = r_vld[DEPTH-1];

`ifdef BENCH_TOGGLE_CNT_EN
    localparam int               SUM_W     = ((CNT_W > 7) ? CNT_W : 7) + 1;
    localparam logic [SUM_W-1:0] C_CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [WIDTH-1:0] r_yprev;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      w_diff;
    logic [SUM_W-1:0] w_sum;

    always_comb begin
        w_diff              = '0;
        w_diff[WIDTH-1:0]   = y_out ^ r_yprev;
    end

    assign w_sum = SUM_W'(r_cnt) + SUM_W'(popcount(w_diff));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_yprev <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_LOAD) begin
            r_yprev <= '0;
            r_cnt   <= '0;
        end else if (y_valid) begin
            r_yprev <= y_out;
            r_cnt   <= (w_sum > C_CNT_MAX) ? {CNT_W{1'b1}} : CNT_W'(w_sum);
        end
    end

    assign toggle_cnt = r_cnt;
`else
    assign toggle_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bench_act_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_bench_act_gen
// Brief   : Scoreboard bench for bench_act_gen (WIDTH=8, DEPTH=3, CNT_W 16/4).
// Revision: 1.0
// ============================================================================
module tb_bench_act_gen;

    localparam int D = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] seed = 8'h00;
    logic [7:0] x_in = 8'h00;

    logic [7:0]  y_out, y_out4;
    logic        y_valid, y_valid4, busy, busy4, done, done4;
    logic [15:0] toggle_cnt;
    logic [3:0]  toggle_cnt4;

    bench_act_gen #(.WIDTH(8), .DEPTH(D), .CNT_W(16), .TAPS(8'hB8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .seed(seed), .x_in(x_in), .y_out(y_out), .y_valid(y_valid),
        .busy(busy), .done(done), .toggle_cnt(toggle_cnt)
    );

    bench_act_gen #(.WIDTH(8), .DEPTH(D), .CNT_W(4), .TAPS(8'hB8)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .seed(seed), .x_in(x_in), .y_out(y_out4), .y_valid(y_valid4),
        .busy(busy4), .done(done4), .toggle_cnt(toggle_cnt4)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_done = 0;
    int         n_valid = 0;
    bit         sb_en = 1'b0;
    logic [7:0] exp_q[$];
    int         exp_tog16;
    int         exp_tog4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    function automatic logic [7:0] f_model(input logic [1:0] m, input logic [7:0] x,
                                           input logic [7:0] s, input logic [7:0] l);
        case (m)
            2'b00:   return ~(x | s);
            2'b01:   return x ^ s;
            2'b10:   return x & l;
            default: return l;
        endcase
    endfunction

    function automatic int ones(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) n_done++;
    end

    // Monitor: pops an expected sample whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst_n && sb_en) begin
            if (y_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got y_out=%0h with empty scoreboard", y_out);
                end else begin
                    chk("y_out", y_out, exp_q.pop_front());
                end
            end
            if (done) begin
                chk("done_with_last_valid", {30'd0, y_valid, busy}, 32'd3);
                chk("done_sb_empty", exp_q.size(), 0);
            end
        end
    end

    task automatic run(input logic [1:0] m, input logic [7:0] sd, input logic [7:0] x,
                       input int n, input bit poke_start);
        logic [7:0] s, l, prev;
        int edges, v0, d0;
        v0 = n_valid;
        d0 = n_done;
        exp_tog16 = 0;
        exp_tog4 = 0;
        start = 1'b1; mode = m; seed = sd;
        @(posedge clk); #1;
        chk("busy_in_load", busy, 1);
        start = 1'b0;
        @(posedge clk); #1;
        // Capture is done; scramble mode/seed to prove they were latched.
        mode = ~m; seed = ~sd;
        s = 8'h00;
        l = (sd == 8'h00) ? 8'h01 : sd;
        prev = 8'h00;
        for (int i = 0; i < n; i++) begin
            x_in  = x;
            stop  = (i == n - 1);
            start = poke_start && (i % 3 == 1);
            s = f_model(m, x, s, l);
            l = lfsr_adv(l);
            exp_q.push_back(s);
            exp_tog16 = exp_tog16 + ones(s ^ prev);
            if (exp_tog16 > 65535) exp_tog16 = 65535;
            exp_tog4 = exp_tog4 + ones(s ^ prev);
            if (exp_tog4 > 15) exp_tog4 = 15;
            prev = s;
            @(posedge clk); #1;
        end
        stop = 1'b0; start = 1'b0; x_in = 8'hA5;
        edges = 0;
        while (!done && edges < 10) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("done_latency", edges, D - 1);
        chk("busy_at_done", busy, 1);
        @(posedge clk); #1;
        chk("busy_idle", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("y_valid_idle", y_valid, 0);
        chk("y_out_hold", y_out, prev);
        chk("valid_count", n_valid - v0, n);
        chk("done_count", n_done - d0, 1);
        chk("sb_drained", exp_q.size(), 0);
`ifdef BENCH_TOGGLE_CNT_EN
        chk("toggle_cnt", toggle_cnt, exp_tog16);
        chk("toggle_cnt_w4", toggle_cnt4, exp_tog4);
`else
        chk("toggle_cnt_off", toggle_cnt, 0);
        chk("toggle_cnt_w4_off", toggle_cnt4, 0);
`endif
    endtask

    initial begin
        int d0;
        #12;
        chk("rst_y_out", y_out, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_toggle_cnt", toggle_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset in the middle of a run.
        start = 1'b1; mode = 2'b01; seed = 8'h00;
        @(posedge clk); #1;
        start = 1'b0; x_in = 8'h01;
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", busy, 1);
        d0 = n_done;
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_y_out", y_out, 0);
        chk("midrun_rst_y_valid", y_valid, 0);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_done", done, 0);
        chk("midrun_rst_toggle_cnt", toggle_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no_done_after_rst", n_done - d0, 0);
        chk("idle_after_rst", busy, 0);
        sb_en = 1'b1;

        run(2'b01, 8'h5A, 8'h01, 10, 1'b0);   // alternating 01/00, 10 toggles
        run(2'b00, 8'h00, 8'h00,  4, 1'b0);   // FF,00,FF,00 -> 32 toggles
        run(2'b11, 8'h00, 8'h33, 20, 1'b1);   // pure LFSR from zero seed
        run(2'b00, 8'h00, 8'h00,  3, 1'b0);   // 24 toggles; 4-bit counter pins at 15
        run(2'b10, 8'hC3, 8'hF0,  6, 1'b0);   // AND with LFSR

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
